// File: rtl/sram_bank_pkg.sv
// sram_bank_pkg
// Shared types and helpers for the sram_bank storage block.
//   state_t        : controller states (RST, INIT, READY)
//   DEF_*          : default parameter values of the bank
//   be_width()     : number of byte strobes for a given word width
//   addr_in_range(): unsigned, full-width address bound check
package sram_bank_pkg;

    typedef enum logic [1:0] {
        RST   = 2'd0,
        INIT  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam int DEF_ADDR_W = 20;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 1024;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

    // Both operands are zero-extended to 64 bits so the compare is unsigned
    // at the full request width; an address never wraps into the array.
    function automatic logic addr_in_range(input logic [63:0] addr,
                                           input logic [63:0] depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/sram_bank_if.sv
// sram_bank_if
// Request/response port of the storage bank.
//   req_valid/req_ready : request handshake (accept when both high)
//   req_write           : 1 = write, 0 = read
//   req_addr            : word address, ADDR_W bits
//   req_wdata/req_be    : write data and per-byte strobes
//   rsp_valid           : one-cycle response pulse, no back-pressure
//   rsp_rdata/rsp_err   : read data and out-of-range flag
// Modports: master (requester side), slave (bank side).
interface sram_bank_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
) ();
    import sram_bank_pkg::*;

    localparam int BE_W = be_width(DATA_W);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/sram_array.sv
// sram_array
// Plain word storage: per-byte write enable, registered (synchronous) read.
// No reset and no handshake; the caller guarantees addr < DEPTH.
//   clk   : clock
//   we/be : write enable and byte strobes
//   re    : read enable, rdata updates on the following edge
//   addr  : word index
//   wdata : write data
//   rdata : registered read data
module sram_array
    import sram_bank_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int BE_W   = be_width(DATA_W)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sram_bank.sv
// sram_bank
// Synchronous storage bank behind a valid/ready request port with a fixed
// one-cycle response. One request is accepted per cycle; responses come back
// in order with no back-pressure.
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sram_bank_if.slave (request + response signals)
// Optional build macro: SRAM_BANK_ZERO_INIT_EN
//   defined   -> after reset the INIT state writes zero to every word, one
//                per cycle, before the bank reports ready.
//   undefined -> bank is ready one cycle after reset release, contents are
//                undefined until written.
module sram_bank
    import sram_bank_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    sram_bank_if.slave bus
);

    localparam int BE_W = be_width(DATA_W);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            state_q;
    state_t            state_d;
    logic              ready;
    logic              accept;
    logic              in_range;

    logic              arr_we;
    logic              arr_re;
    logic [AW-1:0]     arr_addr;
    logic [BE_W-1:0]   arr_be;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;

    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              rsp_read_q;
    logic [DATA_W-1:0] rdata_hold_q;
    logic [DATA_W-1:0] rsp_rdata;

`ifdef SRAM_BANK_ZERO_INIT_EN
    logic [AW-1:0]     init_cnt_q;
    logic              init_last;

    assign init_last = (init_cnt_q == AW'(DEPTH - 1));

    // Counter is held at 0 outside INIT, so any reset (including one that
    // lands mid-walk) restarts the zero-fill from word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt_q <= '0;
        end else if (state_q == INIT) begin
            init_cnt_q <= init_cnt_q + AW'(1);
        end else begin
            init_cnt_q <= '0;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            RST: begin
`ifdef SRAM_BANK_ZERO_INIT_EN
                state_d = INIT;
`else
                state_d = READY;
`endif
            end
            INIT: begin
`ifdef SRAM_BANK_ZERO_INIT_EN
                if (init_last) begin
                    state_d = READY;
                end
`else
                state_d = READY;
`endif
            end
            READY: begin
                ready = 1'b1;
            end
            default: begin
                state_d = RST;
            end
        endcase
    end

    assign accept   = bus.req_valid && ready;
    assign in_range = addr_in_range(64'(bus.req_addr), 64'(DEPTH));

    // ------------------------------------------------------------------
    // Array port mux: the init walker owns the port during INIT, the
    // request port owns it otherwise. Out-of-range requests never touch
    // the array.
    // ------------------------------------------------------------------
    always_comb begin
        arr_we    = accept && bus.req_write && in_range;
        arr_re    = accept && !bus.req_write && in_range;
        arr_addr  = bus.req_addr[AW-1:0];
        arr_be    = bus.req_be;
        arr_wdata = bus.req_wdata;
`ifdef SRAM_BANK_ZERO_INIT_EN
        if (state_q == INIT) begin
            arr_we    = 1'b1;
            arr_re    = 1'b0;
            arr_addr  = init_cnt_q;
            arr_be    = '1;
            arr_wdata = '0;
        end
`endif
    end

    sram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW),
        .BE_W   (BE_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (arr_addr),
        .be    (arr_be),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // ------------------------------------------------------------------
    // Response path. The array read register cannot be reset, so the
    // visible read data is muxed: array output during a read response,
    // zero during write/error responses, and a resettable hold register
    // otherwise so rsp_rdata keeps its last value between responses.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_read_q   <= 1'b0;
            rdata_hold_q <= '0;
        end else begin
            rsp_valid_q <= accept;
            rsp_err_q   <= accept && !in_range;
            rsp_read_q  <= accept && !bus.req_write && in_range;
            if (rsp_valid_q) begin
                rdata_hold_q <= rsp_rdata;
            end
        end
    end

    always_comb begin
        rsp_rdata = rdata_hold_q;
        if (rsp_valid_q) begin
            rsp_rdata = rsp_read_q ? arr_rdata : '0;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata;

endmodule

// File: tb/tb_sram_bank.sv
// tb_sram_bank
// Directed bench for sram_bank: a vector table of single transactions plus
// hand-written sequences for reset, ready latency, back-to-back traffic and
// mid-operation reset. Inputs change on the falling edge, outputs are
// sampled on the falling edge.
// Build with SRAM_BANK_ZERO_INIT_EN defined to exercise the zero-fill (DEPTH=16).
module tb_sram_bank;
    import sram_bank_pkg::*;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;
`ifdef SRAM_BANK_ZERO_INIT_EN
    localparam int DEPTH     = 16;
    localparam int EXP_READY = DEPTH + 1;
`else
    localparam int DEPTH     = 1024;
    localparam int EXP_READY = 1;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    sram_bank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_bank #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [3:0]        be;
        logic              exp_err;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
    endtask

    task automatic drive(input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [3:0] be);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
    endtask

    // Call on a falling edge with the bank ready; returns on the next
    // falling edge after checking the response to this single request.
    task automatic txn(input string tag, input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input logic [3:0] be,
                       input logic exp_err, input logic [DATA_W-1:0] exp_rdata);
        drive(wr, addr, wdata, be);
        @(negedge clk);
        idle();
        check({tag, ".valid"}, 64'(bus.rsp_valid), 64'(1));
        check({tag, ".err"},   64'(bus.rsp_err),   64'(exp_err));
        check({tag, ".rdata"}, 64'(bus.rsp_rdata), 64'(exp_rdata));
    endtask

    // Counts falling edges after reset release until req_ready is seen;
    // returns -1 if the bound expires.
    task automatic wait_ready(output int n);
        n = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) begin
                n = k;
                return;
            end
        end
        n = -1;
    endtask

    initial begin
        int n;
        int spurious;
        logic [DATA_W-1:0] exp_word;

        checks   = 0;
        failures = 0;

        //             wr    addr               wdata          be       err   rdata
        vecs[0]  = '{1'b1, 20'd0,           32'h0BADF00D, 4'hF,   1'b0, 32'h0};
        vecs[1]  = '{1'b1, 20'd5,           32'hDEADBEEF, 4'hF,   1'b0, 32'h0};
        vecs[2]  = '{1'b0, 20'd5,           32'h0,        4'h0,   1'b0, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 20'd5,           32'h11223344, 4'b0101, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 20'd5,           32'h0,        4'h0,   1'b0, 32'hDE22BE44};
        vecs[5]  = '{1'b1, 20'd5,           32'hFFFFFFFF, 4'h0,   1'b0, 32'h0};
        vecs[6]  = '{1'b0, 20'd5,           32'h0,        4'h0,   1'b0, 32'hDE22BE44};
        vecs[7]  = '{1'b0, 20'd1024,        32'h0,        4'h0,   1'b1, 32'h0};
        vecs[8]  = '{1'b1, 20'd1024,        32'h12345678, 4'hF,   1'b1, 32'h0};
        vecs[9]  = '{1'b0, 20'd0,           32'h0,        4'h0,   1'b0, 32'h0BADF00D};
        vecs[10] = '{1'b1, 20'(DEPTH - 1),  32'hCAFEF00D, 4'hF,   1'b0, 32'h0};
        vecs[11] = '{1'b0, 20'(DEPTH - 1),  32'h0,        4'h0,   1'b0, 32'hCAFEF00D};

        idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.ready", 64'(bus.req_ready), 64'(0));
        check("reset.valid", 64'(bus.rsp_valid), 64'(0));
        check("reset.rdata", 64'(bus.rsp_rdata), 64'(0));
        check("reset.err",   64'(bus.rsp_err),   64'(0));

        rst_n = 1'b1;
        wait_ready(n);
        check("ready_latency", 64'(n), 64'(EXP_READY));

`ifdef SRAM_BANK_ZERO_INIT_EN
        // Reset pulse in the middle of the zero-fill restarts it from word 0.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("init_mid.ready", 64'(bus.req_ready), 64'(0));
        rst_n = 1'b0;
        @(negedge clk);
        check("init_rst.ready", 64'(bus.req_ready), 64'(0));
        rst_n = 1'b1;
        wait_ready(n);
        check("init_restart_latency", 64'(n), 64'(DEPTH + 1));

        for (int i = 0; i < DEPTH; i++) begin
            txn($sformatf("zero[%0d]", i), 1'b0, 20'(i), 32'h0, 4'h0, 1'b0, 32'h0);
        end
`endif

        for (int i = 0; i < 12; i++) begin
            txn($sformatf("vec[%0d]", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                vecs[i].be, vecs[i].exp_err, vecs[i].exp_rdata);
        end

        // Top-of-range address must also be rejected.
        txn("oor_max", 1'b0, 20'hFFFFF, 32'h0, 4'h0, 1'b1, 32'h0);

        // Read data holds after the response pulse; err stays low.
        txn("hold_rd", 1'b0, 20'd5, 32'h0, 4'h0, 1'b0, 32'hDE22BE44);
        @(negedge clk);
        check("hold.valid", 64'(bus.rsp_valid), 64'(0));
        check("hold.err",   64'(bus.rsp_err),   64'(0));
        check("hold.rdata", 64'(bus.rsp_rdata), 64'(32'hDE22BE44));

        // Write then read of the same word on consecutive cycles.
        drive(1'b1, 20'd7, 32'hA5A5A5A5, 4'hF);
        @(negedge clk);
        check("b2b_wr.valid", 64'(bus.rsp_valid), 64'(1));
        check("b2b_wr.rdata", 64'(bus.rsp_rdata), 64'(0));
        drive(1'b0, 20'd7, 32'h0, 4'h0);
        @(negedge clk);
        idle();
        check("b2b_rd.valid", 64'(bus.rsp_valid), 64'(1));
        check("b2b_rd.rdata", 64'(bus.rsp_rdata), 64'(32'hA5A5A5A5));

        // Eight back-to-back writes then eight back-to-back reads (addr 8..15).
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 20'(8 + i), 32'h1000_0000 + 32'(i * 32'h0101), 4'hF);
            @(negedge clk);
            check($sformatf("burst_wr[%0d].valid", i), 64'(bus.rsp_valid), 64'(1));
        end
        idle();
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drive(1'b0, 20'(8 + i), 32'h0, 4'h0);
            else       idle();
            if (i > 0) begin
                exp_word = 32'h1000_0000 + 32'((i - 1) * 32'h0101);
                check($sformatf("burst_rd[%0d].valid", i - 1), 64'(bus.rsp_valid), 64'(1));
                check($sformatf("burst_rd[%0d].rdata", i - 1), 64'(bus.rsp_rdata), 64'(exp_word));
            end
            if (i < 8) @(negedge clk);
        end
        @(negedge clk);
        check("burst_end.valid", 64'(bus.rsp_valid), 64'(0));

        // Reset right after a read accept: the response is dropped.
        drive(1'b0, 20'd5, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        idle();
        #1;
        check("midrst.valid", 64'(bus.rsp_valid), 64'(0));
        check("midrst.rdata", 64'(bus.rsp_rdata), 64'(0));
        check("midrst.err",   64'(bus.rsp_err),   64'(0));
        check("midrst.ready", 64'(bus.req_ready), 64'(0));
        spurious = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) spurious++;
        end

        // A request held across reset release is ignored until ready.
        drive(1'b1, 20'd5, 32'h0, 4'hF);
        rst_n = 1'b1;
        n = -1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) spurious++;
            if (bus.req_ready === 1'b1) begin
                n = k;
                break;
            end
        end
        idle();
        check("norsp_while_not_ready", 64'(spurious), 64'(0));
        check("ready_after_midrst", 64'(n), 64'(EXP_READY));

`ifdef SRAM_BANK_ZERO_INIT_EN
        txn("after_rst_rd5", 1'b0, 20'd5, 32'h0, 4'h0, 1'b0, 32'h0);
`else
        txn("after_rst_rd5", 1'b0, 20'd5, 32'h0, 4'h0, 1'b0, 32'hDE22BE44);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_bank.md
Name: sram_bank

Overview:
- Parametrised successor to the single-port byte SRAM: a synchronous storage bank behind a valid/ready request port and a registered response port.
- Adds per-byte write strobes, a response valid, out-of-range error reporting, reset, and an optional zero-fill after reset.
- Sits between the MMU address decode and the CPU load/store path; one request accepted per cycle.

Parameters:
- ADDR_W, 20, request address width in words.
- DATA_W, 32, word width; must be a multiple of 8.
- DEPTH, 1024, number of words implemented; DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  sole clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  bank can accept a request this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte strobes; bit i enables byte i (bits 8i+7:8i)
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  read data
- rsp_err  out  1  qualifies rsp_valid; address out of range

Behaviour:
- Reset (rst_n low, async):
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; FSM enters RST.
  - Array contents are not reset, except by the optional feature.
- FSM states RST, INIT, READY:
  - RST goes to READY (or INIT with the feature) on the first clk edge after rst_n rises.
  - req_ready=1 only in READY.
- Accept: req_valid && req_ready at a rising edge. There is no response back-pressure; the consumer is always ready.
- Read (req_write=0, req_addr<DEPTH):
  - rsp_valid=1 exactly one cycle after accept.
  - rsp_rdata=mem[req_addr]; rsp_err=0.
- Write (req_write=0 is read; req_write=1 is write), req_addr<DEPTH:
  - Enabled bytes are updated at the accept edge; disabled bytes are kept.
  - rsp_valid=1 next cycle as acknowledge; rsp_rdata=0; rsp_err=0.
  - req_be=0 is a legal no-op write and is still acknowledged.
- Out of range (req_addr>=DEPTH):
  - No array access.
  - rsp_valid=1 next cycle, rsp_err=1, rsp_rdata=0.
- Back-to-back traffic:
  - Full throughput: one accept per cycle, responses in order, latency fixed at 1.
  - A read accepted the cycle after a write to the same address returns the new data.
- rsp_rdata holds its last value while rsp_valid=0. rsp_err is 0 whenever rsp_valid=0.
- req_valid while req_ready=0 is ignored; there is no queuing.
- Reset mid-operation: any pending response is dropped (rsp_valid=0); a write accepted at the same edge as reset assertion is not guaranteed.
- Address compare is unsigned at full ADDR_W; no wrap-around.

Optional Feature:
- Macro: SRAM_BANK_ZERO_INIT_EN.
- Defined:
  - RST goes to INIT, where a counter walks 0..DEPTH-1 writing zero, one word per cycle.
  - Transitions to READY after writing word DEPTH-1; req_ready first goes high DEPTH+1 cycles after reset release.
  - Reset during INIT restarts the counter at 0.
- Undefined:
  - INIT and its counter are absent; req_ready=1 one cycle after reset release.
  - Read-before-write contents are undefined (X in simulation).

Decomposition:
- Package sram_bank_pkg:
  - state enum {RST, INIT, READY};
  - localparam helper for BE_W = DATA_W/8;
  - function for the in-range check.
- Sub-module sram_array: storage with per-byte write enable and synchronous read; no reset, no handshake.
- sram_bank holds the FSM, init counter, range check and response registers.

Test Plan:
- Reset release (feature off) -> req_ready=1 on the 1st edge; write addr 5 data 0xDEADBEEF be 0xF, then read 5 -> rsp_valid one cycle after each accept; read returns 0xDEADBEEF, rsp_err=0.
- Partial write: addr 5 data 0x11223344 be 0b0101 over 0xDEADBEEF -> read 5 returns 0xDE22BE44.
- Back-to-back: write addr 7 = 0xA5A5A5A5 then read 7 on the next cycle -> 0xA5A5A5A5; 8 consecutive reads with req_valid held high give 8 consecutive rsp_valid cycles in address order.
- Out of range: DEPTH=1024, read addr 1024 -> rsp_valid=1, rsp_err=1, rdata=0; write addr 1024 then read 0 -> word 0 unchanged.
- Feature on, DEPTH=16: req_ready low for 17 cycles after release; reading all 16 words returns 0; rst_n pulse at init cycle 8 -> full 17-cycle init restarts.
- Mid-operation reset: assert rst_n=0 the cycle after a read accept -> rsp_valid never pulses; outputs 0 during reset.
